// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a borrow flop
// consume the operands LSB first, one bit per clock, over WIDTH RUN cycles.
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_q;
  logic               br;
  logic [CNT_W-1:0]   cnt;
  logic               d, br_next, last_bit, accept;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fsub(input logic ai, input logic bi, input logic bin);
    logic dd, bo;
    dd = ai ^ bi ^ bin;
    bo = (~ai & bi) | (~(ai ^ bi) & bin);
    return {bo, dd};
  endfunction

  assign {br_next, d} = fsub(a_sr[0], b_sr[0], br);
  assign last_bit     = (cnt == CNT_W'(WIDTH - 1));
  assign accept       = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sr   <= a;
        b_sr   <= b;
        res_sr <= '0;
        br     <= 1'b0;
        cnt    <= '0;
      end else if (state_q == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= {d, res_sr[WIDTH-1:1]};
        br     <= br_next;
        cnt    <= cnt + CNT_W'(1);
        // Outputs update only with the completed word, never mid-operation.
        if (last_bit) begin
          diff_q   <= {d, res_sr[WIDTH-1:1]};
          borrow_q <= br_next;
        end
      end
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial (WIDTH=8): stimulus queues expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_sub_serial;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow;
  logic [W-1:0] diff;

  int tests = 0;
  int fails = 0;
  logic [W:0] exp_q[$];

  sub_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got diff=%0h borrow=%0b expected no done", diff, borrow);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({borrow, diff} !== e) begin
          fails++;
          $display("FAIL result: got diff=%0h borrow=%0b expected diff=%0h borrow=%0b",
                   diff, borrow, e[W-1:0], e[W]);
        end
      end
    end
  end

  // Raises start with operands for one edge; optionally queues the expected result.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push);
    logic [W-1:0] dexp;
    logic         bexp;
    dexp = av - bv;
    bexp = (av < bv);
    a = av;
    b = bv;
    start = 1'b1;
    if (push) exp_q.push_back({bexp, dexp});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge inside the DONE cycle, or flags a timeout.
  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 5 - 3: busy for exactly 8 cycles, then one done
    start_op(8'd5, 8'd3, 1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk($sformatf("run_busy_%0d", i), {busy, done}, 2'b10);
    end
    @(negedge clk);
    chk("done_cycle", {busy, done}, 2'b01);
    @(negedge clk);
    chk("after_done", {busy, done}, 2'b00);
    chk("hold_diff", diff, 8'd2);
    chk("hold_borrow", borrow, 0);

    // 3 - 5
    start_op(8'd3, 8'd5, 1);
    wait_done(W + 4, "op_3_5");
    @(negedge clk);

    // 0 - 1, then equal operands
    start_op(8'h00, 8'h01, 1);
    wait_done(W + 4, "op_0_1");
    @(negedge clk);
    start_op(8'hA5, 8'hA5, 1);
    // diff must keep the previous result while RUN is in progress
    @(negedge clk);
    chk("no_partial_diff", diff, 8'hFF);
    chk("no_partial_borrow", borrow, 1);
    wait_done(W + 4, "op_a5_a5");
    @(negedge clk);

    // b = 0 boundary
    start_op(8'h3C, 8'h00, 1);
    wait_done(W + 4, "op_b0");
    @(negedge clk);

    // Start during RUN cycle 3 must be ignored
    start_op(8'd10, 8'd4, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'd1;
    b = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(W + 4, "op_10_4");
    count_dones(W + 6, n);
    chk("ignored_start_no_second_done", n, 0);
    chk("ignored_start_idle", busy, 0);

    // Back-to-back start inside the DONE cycle
    start_op(8'd7, 8'd9, 1);
    wait_done(W + 4, "op_7_9");
    start_op(8'd200, 8'd100, 1);
    @(negedge clk);
    chk("b2b_run_reentered", {busy, done}, 2'b10);
    wait_done(W + 4, "op_200_100");
    @(negedge clk);

    // Reset at RUN cycle 4 aborts with no done pulse
    start_op(8'd50, 8'd20, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    count_dones(W + 6, n);
    chk("abort_no_done", n, 0);

    // Random operands; inputs are scrambled during RUN to confirm capture-only use
    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      start_op(ra, rb, 1);
      a = W'($urandom);
      b = W'($urandom);
      wait_done(W + 4, "random");
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
